// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch front end: constants, FSM states, FIFO entry layout.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          DEPTH_DEF    = 4;

  // At most one memory request is ever outstanding; DROP means the request
  // still on the bus belongs to a path that a redirect has already abandoned.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // One prefetched word together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits are discarded.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory handshake, hazard/redirect inputs and F/D outputs.
// Latency: n/a (wiring only).
// Backpressure: imem_req holds until imem_ack; stallD holds the head word.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stallD;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        validF;
  logic [31:0] instrF;
  logic [31:0] pcF;

  // master: the fetch unit itself
  modport master (
    output imem_req, imem_addr, validF, instrF, pcF,
    input  imem_ack, imem_rdata, stallD, redirect, redirect_addr
  );

  // slave: instruction memory plus the decode/hazard side
  modport slave (
    input  imem_req, imem_addr, validF, instrF, pcF,
    output imem_ack, imem_rdata, stallD, redirect, redirect_addr
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with push/pop/flush; head is visible combinationally.
// Latency: a pushed word is at the head the cycle after the push edge when the FIFO was empty.
// Backpressure: pop ignored when empty, push ignored when full unless a pop frees a slot; flush wins.
// Ports: clk, rst_n, push_i, pop_i, flush_i, wdata_i -> head_o, count_o, full_o, empty_o.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  wdata_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only trusted while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC generation, single-outstanding imem req/ack, prefetch FIFO, redirect flush.
// Latency: request rises the edge after IDLE; a word acked on edge N is at the head after edge N.
// Backpressure: no new request while the FIFO is full; stallD holds the head; redirect flushes all.
// Ports: clk, Reset (async active-low), bus (master modport: imem req/ack, stallD, redirect, F outputs).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = DEPTH_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  Reset,
  instr_fetch_unit_if.master    bus
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;

  logic          fifo_push, fifo_pop, fifo_flush;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_wdata, fifo_head;

  // Redirect outranks everything on its edge: it flushes, blocks the pop
  // and suppresses the push of any word returning on that same edge.
  assign fifo_flush = bus.redirect;
  assign fifo_pop   = !fifo_empty && !bus.stallD && !bus.redirect;

  // In WAIT fetch_pc still equals the address on the bus, so it tags the word.
  assign fifo_wdata = '{pc: fetch_pc_q, instr: bus.imem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    fifo_push  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.redirect && (fifo_count < DEPTH_C)) begin
          state_d = ST_WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      ST_WAIT: begin
        if (bus.imem_ack) begin
          state_d = ST_IDLE;
          if (!bus.redirect) begin
            fifo_push  = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (bus.redirect) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (bus.imem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.redirect) fetch_pc_d = word_align(bus.redirect_addr);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (Reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (fifo_wdata),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Requests are gated on free space and only one is in flight, so the
  // returning word always has a slot.
  assert property (@(posedge clk) disable iff (!Reset) !(fifo_push && fifo_full && !fifo_pop));

  assign bus.imem_req  = (state_q != ST_IDLE);
  assign bus.imem_addr = addr_q;
  assign bus.validF    = !fifo_empty;
  assign bus.instrF    = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign bus.pcF       = fifo_empty ? 32'h0     : fifo_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  instr_fetch_unit_if ifc();

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (ifc)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: a queue of fetched {pc,instr} words plus the one outstanding request.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic        m_pending;
  logic        m_stale;
  logic [31:0] m_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc      = 32'h0;
    m_pending = 1'b0;
    m_stale   = 1'b0;
    m_addr    = 32'h0;
  endtask

  task automatic model_step(input logic ack, input logic stall, input logic redir,
                            input logic [31:0] raddr, input logic [31:0] rdata);
    logic pend0;
    int   sz0;
    logic acked;
    pend0 = m_pending;
    sz0   = mq.size();
    acked = pend0 && ack;
    if (redir) begin
      mq.delete();
      m_pc = raddr & 32'hFFFF_FFFC;
      if (pend0 && !acked) m_stale = 1'b1;
    end else begin
      if (sz0 > 0 && !stall) void'(mq.pop_front());
      if (acked && !m_stale) begin
        mq.push_back({m_addr, rdata});
        m_pc = m_pc + 32'd4;
      end
    end
    if (acked) m_pending = 1'b0;
    if (!pend0 && !redir && sz0 < DEPTH) begin
      m_pending = 1'b1;
      m_stale   = 1'b0;
      m_addr    = m_pc;
    end
  endtask

  // Called at a negedge; applies inputs, advances one clock, returns at the next negedge.
  task automatic step(input logic ack, input logic stall, input logic redir, input logic [31:0] raddr);
    logic [31:0] rd;
    rd = (ack && m_pending) ? mem_word(m_addr) : $urandom;
    ifc.imem_ack      = ack;
    ifc.imem_rdata    = rd;
    ifc.stallD        = stall;
    ifc.redirect      = redir;
    ifc.redirect_addr = raddr;
    @(posedge clk);
    model_step(ack, stall, redir, raddr, rd);
    @(negedge clk);
    ifc.imem_ack = 1'b0;
    ifc.redirect = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset             = 1'b0;
    ifc.imem_ack      = 1'b0;
    ifc.imem_rdata    = 32'h0;
    ifc.stallD        = 1'b0;
    ifc.redirect      = 1'b0;
    ifc.redirect_addr = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset             = 1'b0;
    ifc.imem_ack      = 1'b0;
    ifc.imem_rdata    = 32'h0;
    ifc.stallD        = 1'b0;
    ifc.redirect      = 1'b0;
    ifc.redirect_addr = 32'h0;
    #3;
    n_vec++; if (ifc.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b expected 0", ifc.imem_req); end
    n_vec++; if (ifc.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h expected 0", ifc.imem_addr); end
    n_vec++; if (ifc.validF !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b expected 0", ifc.validF); end
    n_vec++; if (ifc.instrF !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h expected 0", ifc.instrF); end
    n_vec++; if (ifc.pcF !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h expected 0", ifc.pcF); end
  endtask

  task automatic test_stream();
    int   pops;
    logic seen_ack;
    logic a;
    pops = 0;
    seen_ack = 1'b0;
    do_reset();
    for (int i = 0; i < 24 && pops < 4; i++) begin
      a = ifc.imem_req;
      step(a, 1'b0, 1'b0, 32'h0);
      if (a && !seen_ack) begin
        seen_ack = 1'b1;
        n_vec++; if (ifc.validF !== 1'b1) begin n_err++; $display("FAIL stream_first_valid got %b expected 1", ifc.validF); end
      end else if (!seen_ack) begin
        n_vec++; if (ifc.validF !== 1'b0) begin n_err++; $display("FAIL stream_early_valid got %b expected 0", ifc.validF); end
      end
      if (ifc.validF === 1'b1) begin
        n_vec++; if (ifc.pcF !== 32'(4 * pops)) begin n_err++; $display("FAIL stream_pc got %h expected %h", ifc.pcF, 32'(4 * pops)); end
        n_vec++; if (ifc.instrF !== mem_word(32'(4 * pops))) begin n_err++; $display("FAIL stream_instr got %h expected %h", ifc.instrF, mem_word(32'(4 * pops))); end
        pops++;
      end
    end
    n_vec++; if (pops != 4) begin n_err++; $display("FAIL stream_count got %0d expected 4", pops); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(ifc.imem_req, 1'b1, 1'b0, 32'h0);
      if (ifc.validF === 1'b1) begin
        n_vec++; if (ifc.pcF !== 32'h0) begin n_err++; $display("FAIL stall_head got %h expected 0", ifc.pcF); end
      end
    end
    n_vec++; if (ifc.imem_req !== 1'b0) begin n_err++; $display("FAIL stall_full_req got %b expected 0", ifc.imem_req); end
    n_vec++; if (ifc.validF !== 1'b1) begin n_err++; $display("FAIL stall_valid got %b expected 1", ifc.validF); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (ifc.validF !== 1'b1) begin n_err++; $display("FAIL stall_pop_valid got %b expected 1", ifc.validF); end
      n_vec++; if (ifc.pcF !== 32'(4 * k)) begin n_err++; $display("FAIL stall_pop_pc got %h expected %h", ifc.pcF, 32'(4 * k)); end
      if (k == 2) begin
        n_vec++; if (ifc.imem_addr !== 32'h10 || ifc.imem_req !== 1'b1) begin n_err++; $display("FAIL stall_resume got req=%b addr=%h expected req=1 addr=10", ifc.imem_req, ifc.imem_addr); end
      end
      step(ifc.imem_req, 1'b0, 1'b0, 32'h0);
    end
    n_vec++; if (ifc.pcF !== 32'h10) begin n_err++; $display("FAIL stall_next_head got %h expected 10", ifc.pcF); end
  endtask

  task automatic test_redirect_wait();
    logic found;
    found = 1'b0;
    do_reset();
    for (int i = 0; i < 30 && !found; i++) begin
      if (ifc.imem_req === 1'b1 && ifc.imem_addr === 32'h8) found = 1'b1;
      else step(ifc.imem_req, 1'b0, 1'b0, 32'h0);
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rw_reach got no request expected addr 8"); end
    step(1'b0, 1'b0, 1'b1, 32'h43);
    n_vec++; if (ifc.validF !== 1'b0) begin n_err++; $display("FAIL rw_valid got %b expected 0", ifc.validF); end
    n_vec++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h8) begin n_err++; $display("FAIL rw_hold got req=%b addr=%h expected req=1 addr=8", ifc.imem_req, ifc.imem_addr); end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (ifc.imem_req !== 1'b0 || ifc.validF !== 1'b0) begin n_err++; $display("FAIL rw_drop got req=%b valid=%b expected 0 0", ifc.imem_req, ifc.validF); end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h40) begin n_err++; $display("FAIL rw_newaddr got req=%b addr=%h expected req=1 addr=40", ifc.imem_req, ifc.imem_addr); end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (ifc.validF !== 1'b1 || ifc.pcF !== 32'h40) begin n_err++; $display("FAIL rw_first got valid=%b pc=%h expected valid=1 pc=40", ifc.validF, ifc.pcF); end
    n_vec++; if (ifc.instrF !== mem_word(32'h40)) begin n_err++; $display("FAIL rw_instr got %h expected %h", ifc.instrF, mem_word(32'h40)); end
  endtask

  task automatic test_redirect_ack();
    logic found;
    found = 1'b0;
    do_reset();
    for (int i = 0; i < 30 && !found; i++) begin
      if (ifc.imem_req === 1'b1 && ifc.imem_addr === 32'h8) found = 1'b1;
      else step(ifc.imem_req, 1'b1, 1'b0, 32'h0);
    end
    n_vec++; if (!found || ifc.validF !== 1'b1 || ifc.pcF !== 32'h0) begin n_err++; $display("FAIL ra_setup got found=%b valid=%b pc=%h expected 1 1 0", found, ifc.validF, ifc.pcF); end
    step(1'b1, 1'b0, 1'b1, 32'h80);
    n_vec++; if (ifc.validF !== 1'b0 || ifc.pcF !== 32'h0 || ifc.instrF !== 32'h0) begin n_err++; $display("FAIL ra_flush got valid=%b pc=%h instr=%h expected 0 0 0", ifc.validF, ifc.pcF, ifc.instrF); end
    n_vec++; if (ifc.imem_req !== 1'b0) begin n_err++; $display("FAIL ra_idle got %b expected 0", ifc.imem_req); end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h80) begin n_err++; $display("FAIL ra_newaddr got req=%b addr=%h expected req=1 addr=80", ifc.imem_req, ifc.imem_addr); end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (ifc.validF !== 1'b1 || ifc.pcF !== 32'h80) begin n_err++; $display("FAIL ra_first got valid=%b pc=%h expected valid=1 pc=80", ifc.validF, ifc.pcF); end
  endtask

  task automatic test_full_pushpop();
    logic found;
    found = 1'b0;
    do_reset();
    for (int i = 0; i < 30 && !found; i++) begin
      if (ifc.imem_req === 1'b1 && ifc.imem_addr === 32'hC) found = 1'b1;
      else step(ifc.imem_req, 1'b1, 1'b0, 32'h0);
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL fp_reach got no request expected addr C"); end
    // push 0xC and pop 0x0 on the same edge
    step(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (ifc.validF !== 1'b1 || ifc.pcF !== 32'h4) begin n_err++; $display("FAIL fp_pushpop got valid=%b pc=%h expected valid=1 pc=4", ifc.validF, ifc.pcF); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (ifc.imem_req === 1'b1 && ifc.imem_addr === 32'h10) found = 1'b1;
      else step(ifc.imem_req, 1'b1, 1'b0, 32'h0);
    end
    step(found, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (ifc.imem_req !== 1'b0) begin n_err++; $display("FAIL fp_full_req got %b expected 0", ifc.imem_req); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (ifc.validF !== 1'b1 || ifc.pcF !== 32'(4 + 4 * k)) begin n_err++; $display("FAIL fp_order got valid=%b pc=%h expected valid=1 pc=%h", ifc.validF, ifc.pcF, 32'(4 + 4 * k)); end
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (k == 0) begin
        n_vec++; if (ifc.imem_req !== 1'b0) begin n_err++; $display("FAIL fp_no_issue got %b expected 0", ifc.imem_req); end
      end
    end
    n_vec++; if (ifc.validF !== 1'b0) begin n_err++; $display("FAIL fp_drained got %b expected 0", ifc.validF); end
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    do_reset();
    for (int i = 0; i < 12 && !found; i++) begin
      if (ifc.imem_req === 1'b1 && ifc.validF === 1'b1) found = 1'b1;
      else step(ifc.imem_req, 1'b1, 1'b0, 32'h0);
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rm_reach got no wait-with-data state expected one"); end
    #2 Reset = 1'b0;
    #1;
    n_vec++; if (ifc.imem_req !== 1'b0 || ifc.validF !== 1'b0) begin n_err++; $display("FAIL rm_async got req=%b valid=%b expected 0 0", ifc.imem_req, ifc.validF); end
    n_vec++; if (ifc.instrF !== 32'h0 || ifc.pcF !== 32'h0) begin n_err++; $display("FAIL rm_async_out got instr=%h pc=%h expected 0 0", ifc.instrF, ifc.pcF); end
    model_reset();
    ifc.stallD = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0) begin n_err++; $display("FAIL rm_restart got req=%b addr=%h expected req=1 addr=0", ifc.imem_req, ifc.imem_addr); end
  endtask

  task automatic test_random();
    logic        a, s, r;
    logic [31:0] ra;
    logic [63:0] head;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      a  = 1'($urandom_range(1, 0));
      s  = ($urandom_range(9, 0) < 3);
      r  = ($urandom_range(31, 0) == 0);
      ra = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : 32'($urandom_range(4095, 0));
      step(a, s, r, ra);
      head = (mq.size() > 0) ? mq[0] : 64'h0;
      n_vec++; if (ifc.imem_req !== m_pending) begin n_err++; $display("FAIL rnd_req cyc %0d got %b expected %b", i, ifc.imem_req, m_pending); end
      n_vec++; if (ifc.imem_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr cyc %0d got %h expected %h", i, ifc.imem_addr, m_addr); end
      n_vec++; if (ifc.validF !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b expected %b", i, ifc.validF, (mq.size() > 0)); end
      n_vec++; if (ifc.pcF !== head[63:32]) begin n_err++; $display("FAIL rnd_pc cyc %0d got %h expected %h", i, ifc.pcF, head[63:32]); end
      n_vec++; if (ifc.instrF !== head[31:0]) begin n_err++; $display("FAIL rnd_instr cyc %0d got %h expected %h", i, ifc.instrF, head[31:0]); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_full_pushpop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
